// File: rtl/paper_pkg.sv
// Shared constants for the paper processor: opcodes, sequencer state encoding
// and the instruction-memory address/data widths.
// Latency: n/a (constants only). Backpressure: n/a.
package paper_pkg;

    // Instruction memory geometry: 4 words of 2 bits.
    localparam int ADDR_W = 2;
    localparam int DATA_W = 2;

    // Opcodes.
    localparam logic [DATA_W-1:0] OP_INC = 2'b00;
    localparam logic [DATA_W-1:0] OP_JNO = 2'b01;
    localparam logic [DATA_W-1:0] OP_HLT = 2'b10;
    localparam logic [DATA_W-1:0] OP_ILL = 2'b11;

    // Sequencer states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_OPND   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/paper_sequencer.sv
// Fetch/execute sequencer: presents pc on addr, decodes INC/JNO/HLT from the
// combinational ROM data and updates pc, acc, ovf, illegal and retired.
// Latency: INC/HLT one cycle, JNO two cycles (EXEC + OPND); no stalls, no backpressure.
// Ports: clk, rst (sync, active high), start (sampled in IDLE/HALTED only),
//        addr/data (ROM read port), acc, ovf, busy, halted, illegal, retired.
module paper_sequencer
    import paper_pkg::*;
#(
    parameter int ACC_WIDTH = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    logic [1:0]           state_q,   state_d;
    logic [ADDR_W-1:0]    pc_q,      pc_d;
    logic [ACC_WIDTH-1:0] acc_q,     acc_d;
    logic                 ovf_q,     ovf_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic [ADDR_W-1:0]    pc_inc;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [CNT_WIDTH-1:0] retired_inc;

    // pc is exactly ADDR_W bits wide, so the increment wraps 3 -> 0 for free.
    assign pc_inc      = pc_q + ADDR_W'(1);
    // One extra bit captures the carry-out that becomes ovf.
    assign acc_sum     = {1'b0, acc_q} + (ACC_WIDTH+1)'(1);
    // Saturating retire counter: hold at all-ones.
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d   = ST_EXEC;
                    pc_d      = '0;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    retired_d = '0;
                end
            end

            ST_EXEC: begin
                case (data)
                    OP_INC: begin
                        acc_d     = acc_sum[ACC_WIDTH-1:0];
                        ovf_d     = acc_sum[ACC_WIDTH];
                        pc_d      = pc_inc;
                        retired_d = retired_inc;
                    end
                    OP_JNO: begin
                        // Step onto the operand word; the instruction retires in OPND.
                        pc_d    = pc_inc;
                        state_d = ST_OPND;
                    end
                    OP_HLT: begin
                        retired_d = retired_inc;
                        state_d   = ST_HALTED;
                    end
                    default: begin
                        // Undefined opcode halts like HLT and leaves a sticky flag.
                        retired_d = retired_inc;
                        illegal_d = 1'b1;
                        state_d   = ST_HALTED;
                    end
                endcase
            end

            ST_OPND: begin
                // data is the jump target; taken only when the last INC did not carry.
                pc_d      = ovf_q ? pc_inc : data;
                retired_d = retired_inc;
                state_d   = ST_EXEC;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign addr    = pc_q;
    assign acc     = acc_q;
    assign ovf     = ovf_q;
    assign illegal = illegal_q;
    assign retired = retired_q;
    assign busy    = (state_q == ST_EXEC) || (state_q == ST_OPND);
    assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_paper_sequencer.sv
// Bench for paper_sequencer: two instances (2-bit and 4-bit accumulator), each
// with a combinational ROM, checked cycle by cycle against an instruction-level model.
// Latency/backpressure: n/a.
module tb_paper_sequencer;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance A: ACC_WIDTH = 2
    logic       rst_a, start_a, ovf_a, busy_a, halted_a, illegal_a;
    logic [1:0] addr_a, data_a, acc_a;
    logic [7:0] retired_a;
    logic [1:0] rom_a [4];
    assign data_a = rom_a[addr_a];

    // Instance B: ACC_WIDTH = 4
    logic       rst_b, start_b, ovf_b, busy_b, halted_b, illegal_b;
    logic [1:0] addr_b, data_b;
    logic [3:0] acc_b;
    logic [7:0] retired_b;
    logic [1:0] rom_b [4];
    assign data_b = rom_b[addr_b];

    paper_sequencer #(.ACC_WIDTH(2), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .addr(addr_a), .data(data_a),
        .acc(acc_a), .ovf(ovf_a), .busy(busy_a), .halted(halted_a),
        .illegal(illegal_a), .retired(retired_a)
    );

    paper_sequencer #(.ACC_WIDTH(4), .CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .addr(addr_b), .data(data_b),
        .acc(acc_b), .ovf(ovf_b), .busy(busy_b), .halted(halted_b),
        .illegal(illegal_b), .retired(retired_b)
    );

    int total = 0;
    int bad   = 0;

    int          m_rom [4];
    logic [17:0] exp_q [$];

    // Packed snapshot: {busy, halted, illegal, ovf, acc[3:0], pc[1:0], retired[7:0]}
    function automatic logic [17:0] pk(int bsy, int hlt, int ill, int ov, int ac, int pc, int rt);
        logic [17:0] v;
        v = {bsy[0], hlt[0], ill[0], ov[0], ac[3:0], pc[1:0], rt[7:0]};
        return v;
    endfunction

    function automatic logic [17:0] obs_a();
        return {busy_a, halted_a, illegal_a, ovf_a, 2'b00, acc_a, addr_a, retired_a};
    endfunction

    function automatic logic [17:0] obs_b();
        return {busy_b, halted_b, illegal_b, ovf_b, acc_b, addr_b, retired_b};
    endfunction

    // Instruction-level interpreter: pushes the expected visible state after
    // the start edge and after each following edge (JNO contributes two entries).
    task automatic build(input int w, input int n);
        int pc, ac, ov, rt, ill, bsy, hlt, op, maxv;
        maxv = (1 << w) - 1;
        pc = 0; ac = 0; ov = 0; rt = 0; ill = 0; bsy = 1; hlt = 0;
        exp_q.delete();
        exp_q.push_back(pk(bsy, hlt, ill, ov, ac, pc, rt));
        while (exp_q.size() < n) begin
            if (hlt != 0) begin
                exp_q.push_back(pk(bsy, hlt, ill, ov, ac, pc, rt));
            end else begin
                op = m_rom[pc];
                if (op == 0) begin
                    ov = (ac == maxv) ? 1 : 0;
                    ac = (ac + 1) & maxv;
                    pc = (pc + 1) % 4;
                    if (rt < 255) rt++;
                    exp_q.push_back(pk(bsy, hlt, ill, ov, ac, pc, rt));
                end else if (op == 1) begin
                    pc = (pc + 1) % 4;
                    exp_q.push_back(pk(bsy, hlt, ill, ov, ac, pc, rt));
                    pc = (ov != 0) ? (pc + 1) % 4 : m_rom[pc];
                    if (rt < 255) rt++;
                    exp_q.push_back(pk(bsy, hlt, ill, ov, ac, pc, rt));
                end else begin
                    if (op == 3) ill = 1;
                    if (rt < 255) rt++;
                    bsy = 0; hlt = 1;
                    exp_q.push_back(pk(bsy, hlt, ill, ov, ac, pc, rt));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int r0, input int r1, input int r2, input int r3);
        rom_a[0] = 2'(r0); rom_a[1] = 2'(r1); rom_a[2] = 2'(r2); rom_a[3] = 2'(r3);
        m_rom[0] = r0 & 3; m_rom[1] = r1 & 3; m_rom[2] = r2 & 3; m_rom[3] = r3 & 3;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0;
        total++;
        if (obs_a() !== 18'h0) begin
            bad++; $display("FAIL reset_a got=%h want=%h", obs_a(), 18'h0);
        end
        total++;
        if (obs_b() !== 18'h0) begin
            bad++; $display("FAIL reset_b got=%h want=%h", obs_b(), 18'h0);
        end
        step();
        total++;
        if (obs_a() !== 18'h0) begin
            bad++; $display("FAIL idle_hold got=%h want=%h", obs_a(), 18'h0);
        end
    endtask

    // Counting loop, optionally holding start high while busy (must be ignored).
    task automatic test_counting_loop(input bit poke_start);
        int want_addr;
        load_a(0, 1, 0, 2);
        build(2, 16);
        pulse_start_a();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (obs_a() !== exp_q[i]) begin
                bad++; $display("FAIL loop_trace cyc=%0d got=%h want=%h", i, obs_a(), exp_q[i]);
            end
            if (i < 13) begin
                want_addr = (i < 12) ? i % 3 : 3;
                total++;
                if (addr_a !== 2'(want_addr) || busy_a !== 1'b1) begin
                    bad++; $display("FAIL loop_addr cyc=%0d got=%0d/%b want=%0d/1", i, addr_a, busy_a, want_addr);
                end
            end
            if (i == 13) begin
                total++;
                if ({halted_a, acc_a, ovf_a, addr_a, retired_a, illegal_a} !== {1'b1, 2'd0, 1'b1, 2'd3, 8'd9, 1'b0}) begin
                    bad++; $display("FAIL loop_final got=h%b acc%0d ovf%b pc%0d ret%0d ill%b want=h1 acc0 ovf1 pc3 ret9 ill0",
                                    halted_a, acc_a, ovf_a, addr_a, retired_a, illegal_a);
                end
            end
            start_a = (poke_start && i >= 1 && i <= 6) ? 1'b1 : 1'b0;
            step();
        end
        start_a = 1'b0;
    endtask

    task automatic test_immediate_halt();
        load_a(2, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        build(2, 4);
        pulse_start_a();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_a() !== exp_q[i]) begin
                bad++; $display("FAIL imm_halt cyc=%0d got=%h want=%h", i, obs_a(), exp_q[i]);
            end
            step();
        end
        total++;
        if ({halted_a, retired_a, acc_a, addr_a} !== {1'b1, 8'd1, 2'd0, 2'd0}) begin
            bad++; $display("FAIL imm_halt_final got=h%b ret%0d acc%0d pc%0d want=h1 ret1 acc0 pc0",
                            halted_a, retired_a, acc_a, addr_a);
        end
    endtask

    task automatic test_illegal();
        load_a(0, 3, $urandom_range(0, 3), $urandom_range(0, 3));
        build(2, 5);
        pulse_start_a();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs_a() !== exp_q[i]) begin
                bad++; $display("FAIL illegal cyc=%0d got=%h want=%h", i, obs_a(), exp_q[i]);
            end
            step();
        end
        total++;
        if ({halted_a, illegal_a, acc_a, addr_a, retired_a} !== {1'b1, 1'b1, 2'd1, 2'd1, 8'd2}) begin
            bad++; $display("FAIL illegal_final got=h%b ill%b acc%0d pc%0d ret%0d want=h1 ill1 acc1 pc1 ret2",
                            halted_a, illegal_a, acc_a, addr_a, retired_a);
        end
    endtask

    task automatic test_wrap();
        bit seen;
        rom_b[0] = 2'd0; rom_b[1] = 2'd0; rom_b[2] = 2'd0; rom_b[3] = 2'd1;
        m_rom[0] = 0; m_rom[1] = 0; m_rom[2] = 0; m_rom[3] = 1;
        build(4, 200);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            total++;
            if (obs_b() !== exp_q[i]) begin
                bad++; $display("FAIL wrap_trace cyc=%0d got=%h want=%h", i, obs_b(), exp_q[i]);
            end
            if (ovf_b === 1'b1) begin
                seen = 1'b1;
                total++;
                if ({acc_b, retired_b} !== {4'd0, 8'd21}) begin
                    bad++; $display("FAIL wrap_ovf got=acc%0d ret%0d want=acc0 ret21", acc_b, retired_b);
                end
            end else begin
                step();
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wrap_timeout got=no ovf want=ovf within 200 cycles");
        end
    endtask

    task automatic test_reset_mid_run();
        load_a(0, 1, 0, 2);
        pulse_start_a();
        step(); step();
        total++;
        if ({busy_a, addr_a} !== {1'b1, 2'd2}) begin
            bad++; $display("FAIL opnd_pre got=busy%b pc%0d want=busy1 pc2", busy_a, addr_a);
        end
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        total++;
        if (obs_a() !== 18'h0) begin
            bad++; $display("FAIL rst_opnd got=%h want=%h", obs_a(), 18'h0);
        end
        rst_a = 1'b1; start_a = 1'b1;
        step();
        rst_a = 1'b0; start_a = 1'b0;
        total++;
        if (obs_a() !== 18'h0) begin
            bad++; $display("FAIL rst_start got=%h want=%h", obs_a(), 18'h0);
        end
        step();
        total++;
        if (obs_a() !== 18'h0) begin
            bad++; $display("FAIL rst_start_after got=%h want=%h", obs_a(), 18'h0);
        end
    endtask

    task automatic test_saturate();
        load_a(0, 0, 0, 0);
        build(2, 300);
        pulse_start_a();
        for (int i = 0; i < 300; i++) begin
            if (i % 10 == 0 || i > 250) begin
                total++;
                if (obs_a() !== exp_q[i]) begin
                    bad++; $display("FAIL sat_trace cyc=%0d got=%h want=%h", i, obs_a(), exp_q[i]);
                end
            end
            step();
        end
        total++;
        if (retired_a !== 8'd255) begin
            bad++; $display("FAIL sat_final got=%0d want=255", retired_a);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            load_a($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            build(2, 24);
            rst_a = 1'b1;
            step();
            rst_a = 1'b0;
            pulse_start_a();
            for (int i = 0; i < 24; i++) begin
                total++;
                if (obs_a() !== exp_q[i]) begin
                    bad++; $display("FAIL rand_trace k=%0d cyc=%0d got=%h want=%h", k, i, obs_a(), exp_q[i]);
                end
                step();
            end
        end
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rom_a[i] = 2'd0; rom_b[i] = 2'd0; m_rom[i] = 0;
        end
        test_reset();
        test_counting_loop(1'b0);
        test_immediate_halt();
        test_illegal();
        // restart from HALTED with illegal set, start poked while busy
        test_counting_loop(1'b1);
        test_counting_loop(1'b0);
        test_reset_mid_run();
        test_wrap();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
